// File: rtl/output_rf_arbiter_if.sv
// rtl/output_rf_arbiter_if.sv - requester-side bus of the output-spin RF arbiter
//
// Ports carried:
//   clear                      flush FIFO, zero write pointer / row count / overflow
//   wr_valid, wr_data, wr_ready capture-word handshake into the 2-entry FIFO
//   rd_req, rd_addr, rd_gnt    readback request, held until rd_gnt
//   rd_data_valid, rd_data, rd_err  read completion, one cycle after rd_gnt
//   wr_count, overflow         capture status
// master = capture/readback logic, slave = arbiter.
interface output_rf_arbiter_if #(
  parameter int NUM_BIT = 50,
  parameter int ADDR_W  = 8
);
  logic               clear;
  logic               wr_valid;
  logic [NUM_BIT-1:0] wr_data;
  logic               wr_ready;
  logic               rd_req;
  logic [ADDR_W-1:0]  rd_addr;
  logic               rd_gnt;
  logic               rd_data_valid;
  logic [NUM_BIT-1:0] rd_data;
  logic               rd_err;
  logic [ADDR_W-1:0]  wr_count;
  logic               overflow;

  modport master (
    output clear, wr_valid, wr_data, rd_req, rd_addr,
    input  wr_ready, rd_gnt, rd_data_valid, rd_data, rd_err, wr_count, overflow
  );

  modport slave (
    input  clear, wr_valid, wr_data, rd_req, rd_addr,
    output wr_ready, rd_gnt, rd_data_valid, rd_data, rd_err, wr_count, overflow
  );
endinterface

// File: rtl/output_rf_arbiter.sv
// rtl/output_rf_arbiter.sv - shares the single-port output-spin RF between capture writes and readback
//
// Ports:
//   i_clk, i_rst   clock, synchronous active-high reset
//   bus            output_rf_arbiter_if.slave (capture push, readback request/response, status)
//   rf_web         RF write enable, active-low
//   rf_a           RF address
//   rf_d           RF write data
//   rf_bweb        RF bit write enable, active-low
//   rf_q           RF read data, valid one cycle after the address
module output_rf_arbiter #(
  parameter int NUM_BIT      = 50,
  parameter int ADDR_W       = 8,
  parameter int NUM_ROW      = 200,
  parameter int STARVE_LIMIT = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  output_rf_arbiter_if.slave bus,
  output logic               rf_web,
  output logic [ADDR_W-1:0]  rf_a,
  output logic [NUM_BIT-1:0] rf_d,
  output logic [NUM_BIT-1:0] rf_bweb,
  input  logic [NUM_BIT-1:0] rf_q
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(NUM_ROW - 1);
  localparam logic [ADDR_W-1:0] ROWS     = ADDR_W'(NUM_ROW);
  localparam logic [SW-1:0]     LIMIT    = SW'(STARVE_LIMIT);

  logic [NUM_BIT-1:0] fifo_mem [2];
  logic               fifo_rd_idx;
  logic               fifo_wr_idx;
  logic [1:0]         fifo_cnt;
  logic               fifo_full;
  logic               fifo_empty;
  logic               push;
  logic               active;
  logic               do_write;
  logic               do_read;
  logic               rd_oob;
  logic [ADDR_W-1:0]  wr_ptr;
  logic [ADDR_W-1:0]  wr_count_q;
  logic [ADDR_W-1:0]  rf_a_q;
  logic               overflow_q;
  logic [SW-1:0]      starve_cnt;
  logic               rd_valid_q;
  logic               rd_err_q;
  logic               rd_valid;
  logic [NUM_BIT-1:0] rd_data_q;
  logic [NUM_BIT-1:0] rd_data_c;

  assign fifo_full  = (fifo_cnt == 2'd2);
  assign fifo_empty = (fifo_cnt == 2'd0);
  assign active     = !i_rst && !bus.clear;

  // wr_ready follows the registered full state, so a pop in a full cycle
  // does not open a slot until the next cycle.
  assign bus.wr_ready = !fifo_full && !bus.clear;
  assign push         = bus.wr_valid && bus.wr_ready && !i_rst;

  // Writes win unless a read has already lost STARVE_LIMIT cycles in a row.
  assign do_write = active && !fifo_empty && (!bus.rd_req || starve_cnt < LIMIT);
  assign do_read  = active && !do_write && bus.rd_req;
  assign rd_oob   = (bus.rd_addr >= ROWS);

  assign bus.rd_gnt   = do_read;
  assign bus.wr_count = wr_count_q;
  assign bus.overflow = overflow_q;

  // A read in flight when reset arrives is dropped rather than completed.
  assign rd_valid          = rd_valid_q && !i_rst;
  assign bus.rd_data_valid = rd_valid;
  assign bus.rd_err        = rd_err_q && !i_rst;

  // rf_q is only valid in the completion cycle, so it is passed through then
  // and held in rd_data_q afterwards.
  assign rd_data_c   = rd_valid ? (rd_err_q ? '0 : rf_q) : rd_data_q;
  assign bus.rd_data = rd_data_c;

  always_comb begin
    rf_web  = 1'b1;
    rf_bweb = '1;
    rf_d    = '0;
    rf_a    = rf_a_q;
    if (i_rst) begin
      rf_a = '0;
    end else if (do_write) begin
      rf_web  = 1'b0;
      rf_bweb = '0;
      rf_a    = wr_ptr;
      rf_d    = fifo_mem[fifo_rd_idx];
    end else if (do_read) begin
      rf_a = rd_oob ? '0 : bus.rd_addr;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      fifo_rd_idx <= 1'b0;
      fifo_wr_idx <= 1'b0;
      fifo_cnt    <= 2'd0;
      wr_ptr      <= '0;
      wr_count_q  <= '0;
      overflow_q  <= 1'b0;
      starve_cnt  <= '0;
      rf_a_q      <= '0;
      rd_valid_q  <= 1'b0;
      rd_err_q    <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      rf_a_q     <= rf_a;
      rd_valid_q <= do_read;
      rd_err_q   <= do_read && rd_oob;
      rd_data_q  <= rd_data_c;

      if (!bus.rd_req || do_read) begin
        starve_cnt <= '0;
      end else if (starve_cnt < LIMIT) begin
        starve_cnt <= starve_cnt + 1'b1;
      end

      if (bus.clear) begin
        fifo_rd_idx <= 1'b0;
        fifo_wr_idx <= 1'b0;
        fifo_cnt    <= 2'd0;
        wr_ptr      <= '0;
        wr_count_q  <= '0;
        overflow_q  <= 1'b0;
      end else begin
        if (push) begin
          fifo_mem[fifo_wr_idx] <= bus.wr_data;
          fifo_wr_idx           <= ~fifo_wr_idx;
        end
        if (do_write) begin
          fifo_rd_idx <= ~fifo_rd_idx;
        end
        fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, do_write};

        if (do_write) begin
          if (wr_ptr == LAST_ROW) begin
            wr_ptr     <= '0;
            overflow_q <= 1'b1;
          end else begin
            wr_ptr <= wr_ptr + 1'b1;
          end
          if (wr_count_q != ROWS) begin
            wr_count_q <= wr_count_q + 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_output_rf_arbiter.sv
// tb/tb_output_rf_arbiter.sv - directed self-checking bench for output_rf_arbiter
module tb_output_rf_arbiter;
  localparam int NUM_BIT = 50;
  localparam int ADDR_W  = 8;
  localparam int NUM_ROW = 200;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  output_rf_arbiter_if #(.NUM_BIT(NUM_BIT), .ADDR_W(ADDR_W)) bus ();

  logic               rf_web;
  logic [ADDR_W-1:0]  rf_a;
  logic [NUM_BIT-1:0] rf_d;
  logic [NUM_BIT-1:0] rf_bweb;
  logic [NUM_BIT-1:0] rf_q;

  output_rf_arbiter #(
    .NUM_BIT(NUM_BIT), .ADDR_W(ADDR_W), .NUM_ROW(NUM_ROW), .STARVE_LIMIT(4)
  ) dut (
    .i_clk(clk), .i_rst(rst), .bus(bus),
    .rf_web(rf_web), .rf_a(rf_a), .rf_d(rf_d), .rf_bweb(rf_bweb), .rf_q(rf_q)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // RF macro model: synchronous single port, one-cycle read latency.
  logic [NUM_BIT-1:0] mem [NUM_ROW];
  always @(posedge clk) begin
    if (rf_a < ADDR_W'(NUM_ROW)) begin
      if (!rf_web) mem[rf_a] <= rf_d;
      rf_q <= mem[rf_a];
    end else begin
      rf_q <= '0;
    end
  end

  // Write scoreboard: every RF write must carry the oldest accepted word to
  // the next sequential row.
  logic [NUM_BIT-1:0] push_q [$];
  int                 exp_row = 0;
  always @(posedge clk) begin
    logic [NUM_BIT-1:0] exp_d;
    if (rst || bus.clear) begin
      push_q.delete();
      exp_row = 0;
    end else begin
      if (!rf_web) begin
        exp_d = '1;
        if (push_q.size() != 0) exp_d = push_q.pop_front();
        check("wr_bweb", 64'(rf_bweb), 64'(0));
        check("wr_row", 64'(rf_a), 64'(exp_row));
        check("wr_data", 64'(rf_d), 64'(exp_d));
        exp_row = (exp_row == NUM_ROW - 1) ? 0 : exp_row + 1;
      end
      if (bus.wr_valid && bus.wr_ready) push_q.push_back(bus.wr_data);
    end
  end

  int   sent;
  int   req_n;
  int   gnt_at;
  logic saw_full;
  logic chk_rd;
  logic acc;

  initial begin
    rst = 1'b1;
    bus.clear = 1'b0; bus.wr_valid = 1'b0; bus.wr_data = '0;
    bus.rd_req = 1'b0; bus.rd_addr = '0;
    tick(); tick();
    @(negedge clk);
    check("rst_web", 64'(rf_web), 64'(1));
    check("rst_bweb", 64'(rf_bweb), 64'({NUM_BIT{1'b1}}));
    check("rst_a", 64'(rf_a), 64'(0));
    check("rst_d", 64'(rf_d), 64'(0));
    check("rst_gnt", 64'(bus.rd_gnt), 64'(0));
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("post_ready", 64'(bus.wr_ready), 64'(1));
    check("post_count", 64'(bus.wr_count), 64'(0));
    check("post_ovf", 64'(bus.overflow), 64'(0));
    check("post_valid", 64'(bus.rd_data_valid), 64'(0));
    check("post_data", 64'(bus.rd_data), 64'(0));
    check("post_err", 64'(bus.rd_err), 64'(0));

    // three words, no reads
    tick();
    for (int k = 0; k < 5; k++) begin
      bus.wr_valid = (k < 3);
      bus.wr_data  = NUM_BIT'(k + 1);
      @(negedge clk);
      check("t1_ready", 64'(bus.wr_ready), 64'(1));
      if (k >= 1 && k <= 3) begin
        check("t1_web", 64'(rf_web), 64'(0));
        check("t1_row", 64'(rf_a), 64'(k - 1));
      end
      tick();
    end
    @(negedge clk);
    check("t1_count", 64'(bus.wr_count), 64'(3));

    // read row 1 with an empty FIFO
    tick();
    bus.rd_req = 1'b1; bus.rd_addr = 8'd1;
    @(negedge clk);
    check("t2_gnt", 64'(bus.rd_gnt), 64'(1));
    check("t2_a", 64'(rf_a), 64'(1));
    check("t2_web", 64'(rf_web), 64'(1));
    tick();
    bus.rd_req = 1'b0;
    @(negedge clk);
    check("t2_valid", 64'(bus.rd_data_valid), 64'(1));
    check("t2_data", 64'(bus.rd_data), 64'(2));
    check("t2_err", 64'(bus.rd_err), 64'(0));
    tick();

    // continuous capture against a held read of row 0
    sent = 0; req_n = 0; gnt_at = 0; saw_full = 1'b0; chk_rd = 1'b0;
    for (int c = 0; c < 24; c++) begin
      bus.wr_valid = (sent < 20);
      bus.wr_data  = NUM_BIT'(32'h100 + sent);
      bus.rd_req   = (c >= 1) && (gnt_at == 0);
      bus.rd_addr  = 8'd0;
      @(negedge clk);
      if (chk_rd) begin
        check("t3_valid", 64'(bus.rd_data_valid), 64'(1));
        check("t3_data", 64'(bus.rd_data), 64'(1));
      end
      chk_rd = bus.rd_gnt;
      if (bus.rd_req) req_n++;
      if (bus.rd_gnt && gnt_at == 0) gnt_at = req_n;
      if (!bus.wr_ready) saw_full = 1'b1;
      acc = bus.wr_valid && bus.wr_ready;
      tick();
      if (acc) sent++;
    end
    bus.wr_valid = 1'b0;
    tick(); tick();
    @(negedge clk);
    check("t3_gnt_cycle", 64'(gnt_at), 64'(5));
    check("t3_saw_full", 64'(saw_full), 64'(1));
    check("t3_sent", 64'(sent), 64'(20));
    check("t3_count", 64'(bus.wr_count), 64'(23));
    check("t3_drained", 64'(push_q.size()), 64'(0));

    // 201 words after reset: wrap and saturation
    tick();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    for (int k = 0; k < 204; k++) begin
      bus.wr_valid = (k < 201);
      bus.wr_data  = NUM_BIT'(32'h5000 + k);
      @(negedge clk);
      if (k == 200) begin
        check("t4_ovf_before", 64'(bus.overflow), 64'(0));
        check("t4_count_199", 64'(bus.wr_count), 64'(199));
      end
      if (k == 201) begin
        check("t4_ovf_set", 64'(bus.overflow), 64'(1));
        check("t4_count_sat", 64'(bus.wr_count), 64'(200));
        check("t4_row0_web", 64'(rf_web), 64'(0));
        check("t4_row0_a", 64'(rf_a), 64'(0));
      end
      tick();
    end
    @(negedge clk);
    check("t4_count_end", 64'(bus.wr_count), 64'(200));
    check("t4_mem0", 64'(mem[0]), 64'(32'h5000 + 200));

    // in-range read, hold, then out-of-range read
    tick();
    bus.rd_req = 1'b1; bus.rd_addr = 8'd5;
    tick();
    bus.rd_req = 1'b0;
    @(negedge clk);
    check("t5_data5", 64'(bus.rd_data), 64'(32'h5005));
    tick();
    @(negedge clk);
    check("t5_hold_valid", 64'(bus.rd_data_valid), 64'(0));
    check("t5_hold_data", 64'(bus.rd_data), 64'(32'h5005));
    tick();
    bus.rd_req = 1'b1; bus.rd_addr = 8'd200;
    @(negedge clk);
    check("t5_oob_gnt", 64'(bus.rd_gnt), 64'(1));
    check("t5_oob_a", 64'(rf_a), 64'(0));
    check("t5_oob_web", 64'(rf_web), 64'(1));
    tick();
    bus.rd_req = 1'b0;
    @(negedge clk);
    check("t5_oob_valid", 64'(bus.rd_data_valid), 64'(1));
    check("t5_oob_err", 64'(bus.rd_err), 64'(1));
    check("t5_oob_data", 64'(bus.rd_data), 64'(0));
    tick();

    // clear with a full FIFO right after a read grant
    sent = 0;
    for (int c = 0; c < 10; c++) begin
      bus.wr_valid = (c <= 6) || (c == 8);
      bus.wr_data  = (c == 8) ? NUM_BIT'(32'hABC) : NUM_BIT'(32'h700 + sent);
      bus.rd_req   = (c >= 1) && (c <= 5);
      bus.rd_addr  = 8'd5;
      bus.clear    = (c == 6);
      @(negedge clk);
      if (c == 5) check("t6_gnt", 64'(bus.rd_gnt), 64'(1));
      if (c == 6) begin
        check("t6_valid", 64'(bus.rd_data_valid), 64'(1));
        check("t6_data", 64'(bus.rd_data), 64'(32'h5005));
        check("t6_clr_gnt", 64'(bus.rd_gnt), 64'(0));
        check("t6_clr_ready", 64'(bus.wr_ready), 64'(0));
        check("t6_clr_web", 64'(rf_web), 64'(1));
      end
      if (c == 7) begin
        check("t6_count0", 64'(bus.wr_count), 64'(0));
        check("t6_ovf0", 64'(bus.overflow), 64'(0));
        check("t6_ready", 64'(bus.wr_ready), 64'(1));
        check("t6_empty_web", 64'(rf_web), 64'(1));
      end
      if (c == 9) begin
        check("t6_push_web", 64'(rf_web), 64'(0));
        check("t6_push_row", 64'(rf_a), 64'(0));
        check("t6_push_d", 64'(rf_d), 64'(32'hABC));
      end
      acc = bus.wr_valid && bus.wr_ready;
      tick();
      if (acc) sent++;
    end
    bus.wr_valid = 1'b0;
    @(negedge clk);
    check("t6_count1", 64'(bus.wr_count), 64'(1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
